// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: default frame length, FSM encoding and
// the levels the synchronizers settle to while the bus is idle.
package spi_pkg;

  localparam int SPI_FRAME_BITS = 40;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_state_e;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCK_IDLE  = 1'b0;
  localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus a history flop that
// yields single-cycle rise/fall pulses on the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES   = 2,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk50M,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;
  logic [STAGES:0]   vld_q, vld_d;

  always_comb begin
    sync_d    = '0;
    sync_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    hist_d = sync_q[STAGES-1];
    vld_d  = {vld_q[STAGES-1:0], 1'b1};
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_VAL}};
      hist_q <= IDLE_VAL;
      vld_q  <= '0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      vld_q  <= vld_d;
    end
  end

  // Edges stay masked until the reset idle level has flushed out of the chain,
  // so an input already at its active level after reset never looks like an edge.
  assign sync = sync_q[STAGES-1];
  assign rise = vld_q[STAGES] &  sync & ~hist_q;
  assign fall = vld_q[STAGES] & ~sync &  hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, fully oversampled in the clk50M domain: full-duplex,
// MSB-first, fixed WIDTH-bit frames with abort and overrun reporting.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_FRAME_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic             cs,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH + 1);

  logic cs_sync, cs_rise, cs_fall;
  logic sck_sync, sck_rise, sck_fall;
  logic mosi_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(CS_IDLE)) u_cs_sync (
    .clk50M (clk50M),
    .rst    (rst),
    .din    (cs),
    .sync   (cs_sync),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_VAL(SCK_IDLE)) u_sck_sync (
    .clk50M (clk50M),
    .rst    (rst),
    .din    (sck),
    .sync   (sck_sync),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
  logic                   mosi_hist_q, mosi_hist_d;

  always_comb begin
    mosi_d    = '0;
    mosi_d[0] = mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_d[i] = mosi_q[i-1];
    end
    mosi_hist_d = mosi_q[SYNC_STAGES-1];
  end

  // mosi shares the depth of the sck chain so data and clock stay aligned;
  // its history flop only keeps the three inputs structurally identical.
  assign mosi_sync = mosi_q[SYNC_STAGES-1];

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rx_valid_q, rx_valid_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             miso_q, miso_d;

  logic [WIDTH-1:0] rx_shift;
  logic [CW-1:0]    cnt_inc;

  assign rx_shift = {rx_sr_q[WIDTH-2:0], mosi_sync};
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    rx_data_d   = rx_data_q;
    cnt_d       = cnt_q;
    rx_valid_d  = 1'b0;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    miso_d      = miso_q;

    unique case (state_q)
      ST_IDLE: begin
        miso_d = 1'b0;
        // Frame start wins over any sck edge seen in the same cycle.
        if (cs_fall) begin
          state_d = ST_SHIFT;
          tx_sr_d = tx_data;
          rx_sr_d = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          miso_d  = tx_data[WIDTH-1];
        end
      end

      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          frame_err_d = 1'b1;
          miso_d      = 1'b0;
        end else if (sck_rise) begin
          rx_sr_d = rx_shift;
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(WIDTH)) begin
            state_d    = ST_DONE;
            rx_data_d  = rx_shift;
            rx_valid_d = 1'b1;
            miso_d     = 1'b0;
          end
        end else if (sck_fall) begin
          tx_sr_d = {tx_sr_q[WIDTH-2:0], 1'b0};
          miso_d  = tx_sr_q[WIDTH-2];
        end
      end

      ST_DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          frame_err_d = overrun_q;
          overrun_d   = 1'b0;
        end else if (sck_rise) begin
          overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        miso_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      cnt_q       <= '0;
      rx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      miso_q      <= 1'b0;
      mosi_q      <= {SYNC_STAGES{MOSI_IDLE}};
      mosi_hist_q <= MOSI_IDLE;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      rx_data_q   <= rx_data_d;
      cnt_q       <= cnt_d;
      rx_valid_q  <= rx_valid_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      miso_q      <= miso_d;
      mosi_q      <= mosi_d;
      mosi_hist_q <= mosi_hist_d;
    end
  end

  assign miso      = miso_q & ~cs_sync;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;

  logic unused_ok;
  assign unused_ok = &{1'b0, sck_sync, mosi_hist_q};

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master at clk50M/16, a scoreboard of
// expected received frames, and pulse counters watched on every falling clock edge.
module tb_spi_slave;

  localparam int W = 40;

  logic         clk50M = 1'b0;
  logic         rst    = 1'b1;
  logic         cs     = 1'b1;
  logic         sck    = 1'b0;
  logic         mosi   = 1'b0;
  logic         miso;
  logic [W-1:0] tx_data = '0;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         busy;
  logic         frame_err;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  int fe_cnt = 0;
  logic [W-1:0] exp_q[$];

  always #10 clk50M = ~clk50M;

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk50M    (clk50M),
    .rst       (rst),
    .cs        (cs),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // Scoreboard side: every rx_valid cycle pops one expected frame.
  always @(negedge clk50M) begin
    if (frame_err) fe_cnt++;
    if (rx_valid) begin
      rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no pulse", rx_data);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_frame: rx_data=%h required %h", rx_data, e);
        end else begin
          $display("rx frame %h ok", rx_data);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // Clocks nbits bits of word (MSB first) without touching cs; cap collects miso.
  task automatic spi_bits(input logic [63:0] word, input int nbits, output logic [63:0] cap);
    cap = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = word[i];
      wait_clk(8);
      cap = {cap[62:0], miso};
      sck = 1'b1;
      if (i == nbits - 11) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_frame: busy=%b required 1", busy);
        end
      end
      wait_clk(8);
      sck = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic spi_frame(input logic [63:0] word, input int nbits, input int gap,
                           output logic [63:0] cap);
    cs = 1'b0;
    wait_clk(10);
    spi_bits(word, nbits, cap);
    wait_clk(8);
    cs = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(5);
    checks += 5;
    if (miso !== 1'b0)      begin errors++; $display("FAIL reset_miso: %b required 0", miso); end
    if (rx_data !== '0)     begin errors++; $display("FAIL reset_rx_data: %h required 0", rx_data); end
    if (rx_valid !== 1'b0)  begin errors++; $display("FAIL reset_rx_valid: %b required 0", rx_valid); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: %b required 0", frame_err); end
    rst = 1'b0;
    wait_clk(10);
    $display("reset checked");
  endtask

  task automatic test_full_frame;
    logic [63:0] cap;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    tx_data = 40'hA5_1234_5678;
    exp_q.push_back(40'h80_0000_0003);
    spi_frame({24'h0, 40'h80_0000_0003}, 40, 10, cap);
    checks += 4;
    if (cap[39:0] !== 40'hA5_1234_5678) begin errors++; $display("FAIL full_miso: %h required a512345678", cap[39:0]); end
    if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL full_rx_valid: %0d pulses required 1", rv_cnt - rv0); end
    if (fe_cnt != fe0)     begin errors++; $display("FAIL full_frame_err: %0d pulses required 0", fe_cnt - fe0); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL full_busy_end: %b required 0", busy); end
    $display("full frame: miso stream %h", cap[39:0]);
  endtask

  task automatic test_abort;
    logic [63:0] cap;
    logic [W-1:0] prior;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt; prior = rx_data;
    spi_frame(64'h1_2345, 17, 10, cap);
    checks += 5;
    if (fe_cnt - fe0 != 1)  begin errors++; $display("FAIL abort_frame_err: %0d pulses required 1", fe_cnt - fe0); end
    if (rv_cnt != rv0)      begin errors++; $display("FAIL abort_rx_valid: %0d pulses required 0", rv_cnt - rv0); end
    if (rx_data !== prior)  begin errors++; $display("FAIL abort_rx_data: %h required %h", rx_data, prior); end
    if (prior !== 40'h80_0000_0003) begin errors++; $display("FAIL abort_prior: %h required 8000000003", prior); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy: %b required 0", busy); end
    $display("abort after 17 bits checked");
  endtask

  task automatic test_overrun;
    logic [63:0] cap;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    tx_data = 40'h0F_EDCB_A987;
    exp_q.push_back(40'h3C_5A5A_0F0F);
    spi_frame({22'h0, 40'h3C_5A5A_0F0F, 2'b11}, 42, 10, cap);
    checks += 5;
    if (rv_cnt - rv0 != 1)  begin errors++; $display("FAIL overrun_rx_valid: %0d pulses required 1", rv_cnt - rv0); end
    if (fe_cnt - fe0 != 1)  begin errors++; $display("FAIL overrun_frame_err: %0d pulses required 1", fe_cnt - fe0); end
    if (rx_data !== 40'h3C_5A5A_0F0F) begin errors++; $display("FAIL overrun_rx_data: %h required 3c5a5a0f0f", rx_data); end
    if (cap[41:2] !== 40'h0F_EDCB_A987) begin errors++; $display("FAIL overrun_miso: %h required 0fedcba987", cap[41:2]); end
    if (cap[1:0] !== 2'b00) begin errors++; $display("FAIL overrun_miso_tail: %b required 00", cap[1:0]); end
    $display("overrun frame of 42 bits checked");
  endtask

  task automatic test_reset_mid_frame;
    logic [63:0] cap;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    tx_data = 40'h12_3456_789A;
    cs = 1'b0;
    wait_clk(10);
    spi_bits(64'hA_BCDE, 20, cap);
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(10);
    cs = 1'b1;
    wait_clk(12);
    checks += 3;
    if (rv_cnt != rv0) begin errors++; $display("FAIL rstmid_rx_valid: %0d pulses required 0", rv_cnt - rv0); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL rstmid_frame_err: %0d pulses required 0", fe_cnt - fe0); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: %b required 0", busy); end
    exp_q.push_back(40'hFF_FFFF_FFFF);
    spi_frame({24'h0, 40'hFF_FFFF_FFFF}, 40, 10, cap);
    checks += 3;
    if (rx_data !== 40'hFF_FFFF_FFFF) begin errors++; $display("FAIL rstmid_rx_data: %h required ffffffffff", rx_data); end
    if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL rstmid_rx_valid_after: %0d pulses required 1", rv_cnt - rv0); end
    if (cap[39:0] !== 40'h12_3456_789A) begin errors++; $display("FAIL rstmid_miso: %h required 123456789a", cap[39:0]); end
    $display("reset mid-frame then full frame checked");
  endtask

  task automatic test_back_to_back;
    logic [63:0] cap1, cap2;
    int rv0, fe0;
    rv0 = rv_cnt; fe0 = fe_cnt;
    tx_data = 40'hC3_DEAD_BEEF;
    exp_q.push_back(40'h01_2345_6789);
    exp_q.push_back(40'hFE_DCBA_9876);
    spi_frame({24'h0, 40'h01_2345_6789}, 40, 4, cap1);
    tx_data = 40'h5A_F00D_CAFE;
    wait_clk(4);
    spi_frame({24'h0, 40'hFE_DCBA_9876}, 40, 10, cap2);
    checks += 4;
    if (cap1[39:0] !== 40'hC3_DEAD_BEEF) begin errors++; $display("FAIL b2b_miso1: %h required c3deadbeef", cap1[39:0]); end
    if (cap2[39:0] !== 40'h5A_F00D_CAFE) begin errors++; $display("FAIL b2b_miso2: %h required 5af00dcafe", cap2[39:0]); end
    if (rv_cnt - rv0 != 2) begin errors++; $display("FAIL b2b_rx_valid: %0d pulses required 2", rv_cnt - rv0); end
    if (fe_cnt != fe0)     begin errors++; $display("FAIL b2b_frame_err: %0d pulses required 0", fe_cnt - fe0); end
    $display("back-to-back frames checked");
  endtask

  task automatic test_cs_high_sck;
    int rv0, fe0, bad_miso, bad_busy;
    rv0 = rv_cnt; fe0 = fe_cnt; bad_miso = 0; bad_busy = 0;
    tx_data = 40'hFF_FFFF_FFFF;
    cs = 1'b1;
    for (int i = 0; i < 20; i++) begin
      mosi = i[0];
      sck = ~sck;
      for (int k = 0; k < 4; k++) begin
        wait_clk(1);
        if (miso !== 1'b0) bad_miso++;
        if (busy !== 1'b0) bad_busy++;
      end
    end
    sck = 1'b0;
    mosi = 1'b0;
    wait_clk(10);
    checks += 4;
    if (bad_miso != 0) begin errors++; $display("FAIL idle_miso: %0d cycles with miso=1 required 0", bad_miso); end
    if (bad_busy != 0) begin errors++; $display("FAIL idle_busy: %0d cycles with busy=1 required 0", bad_busy); end
    if (rv_cnt != rv0) begin errors++; $display("FAIL idle_rx_valid: %0d pulses required 0", rv_cnt - rv0); end
    if (fe_cnt != fe0) begin errors++; $display("FAIL idle_frame_err: %0d pulses required 0", fe_cnt - fe0); end
    $display("cs high with sck toggling checked");
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_abort;
    test_overrun;
    test_reset_mid_frame;
    test_back_to_back;
    test_cs_high_sck;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d frames never received, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 40, frame length in bits.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on cs/sck/mosi.
REQ-003 clk50M  input  1  system clock, 50 MHz; the only clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cs  input  1  SPI chip select, active-low, asynchronous to clk50M.
REQ-006 sck  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous.
REQ-007 mosi  input  1  master-out data, asynchronous.
REQ-008 miso  output  1  slave-out data.
REQ-009 tx_data  input  WIDTH  response frame; captured at frame start.
REQ-010 rx_data  output  WIDTH  last complete received frame.
REQ-011 rx_valid  output  1  one-cycle pulse: rx_data updated.
REQ-012 busy  output  1  high while a frame is in progress.
REQ-013 frame_err  output  1  one-cycle pulse: frame aborted or overrun.

Function
REQ-014 cs, sck, mosi SHALL each pass through SYNC_STAGES flops plus one history flop; edges are detected on synchronized values only.
REQ-015 FSM states SHALL be IDLE, SHIFT, DONE.
REQ-016 IDLE: on synchronized cs falling edge -> SHIFT; tx_data loaded into tx shift register, bit counter cleared, busy=1, miso=tx_data[WIDTH-1] the same cycle.
REQ-017 SHIFT: on each synchronized sck rising edge, mosi (synchronized) shifted into rx shift register LSB, counter +1.
REQ-018 SHIFT: on each synchronized sck falling edge, tx shift register shifts left, miso = next MSB; falling edge after the last rising edge drives 0.
REQ-019 MSB first in both directions.
REQ-020 When counter reaches WIDTH, rx_data SHALL load the rx shift register and rx_valid pulse on the same cycle; state -> DONE.
REQ-021 DONE: further sck edges ignored, miso=0; extra rising edges while cs low set a sticky overrun bit.
REQ-022 DONE: on cs rising edge -> IDLE, busy=0; frame_err pulses if overrun bit set; overrun cleared.
REQ-023 SHIFT: cs rising edge with counter < WIDTH -> IDLE, frame_err pulse, rx_data unchanged, no rx_valid.
REQ-024 cs falling and sck rising detected in the same cycle: frame start takes priority, that sck edge ignored.
REQ-025 miso SHALL be 0 whenever synchronized cs is high.
REQ-026 Edge-detect latency SHALL be SYNC_STAGES+1 clk50M cycles; supported sck frequency at most clk50M/8; cs setup before first sck rising edge at least 8 clk50M cycles.
REQ-027 Bit counter width SHALL be clog2(WIDTH+1); no wrap within a frame.

Reset
REQ-028 rst SHALL force state=IDLE, miso=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, counter=0, overrun=0, shift registers=0, synchronizer flops to idle levels (cs=1, sck=0, mosi=0).
REQ-029 rst asserted mid-frame SHALL abort silently (no rx_valid, no frame_err); next frame needs a fresh cs falling edge.

Structure
REQ-030 Package spi_pkg SHALL hold SPI_FRAME_BITS=40, the FSM state encoding, and the idle levels.
REQ-031 One sub-module, spi_sync_edge (synchronizer + rise/fall pulse), SHALL be instantiated for cs and sck; mosi uses synchronizer only.

Verification
REQ-032 tx_data=40'hA5_1234_5678, master sends 40'h80_0000_0003 at sck=clk50M/16 -> miso stream equals A51234567 8 MSB first; rx_data=40'h8000000003; single rx_valid pulse.
REQ-033 Master raises cs after 17 bits -> frame_err one pulse, no rx_valid, rx_data holds prior value, busy=0.
REQ-034 Master clocks 42 bits -> rx_valid after 40th, frame_err at cs rise, rx_data = first 40 bits.
REQ-035 rst pulsed after 20 bits, then full frame 40'hFF_FFFF_FFFF -> no pulses during reset, rx_data=40'hFFFFFFFFFF afterwards.
REQ-036 Two back-to-back frames, cs high for 8 cycles, tx_data changed between -> second frame's miso reflects new tx_data from bit 39.
REQ-037 cs high with sck toggling -> miso=0, busy=0, no pulses.
